// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one byte from the host to a PS/2 device over the open-drain clock and
// data lines. The host inhibits the clock, raises a request-to-send (data low),
// releases the clock, and then places one frame bit on each device falling
// edge. After the stop bit it samples the device ACK and waits for bus idle.
//
// Ports:
//   board_clk    in  1  system clock
//   reset        in  1  synchronous active-low reset
//   ps2_clk_in   in  1  raw PS/2 clock pin (asynchronous)
//   ps2_data_in  in  1  raw PS/2 data pin (asynchronous)
//   ps2_clk_oe   out 1  1 pulls PS/2 clock low
//   ps2_data_oe  out 1  1 pulls PS/2 data low
//   tx_data      in  8  byte to send, sampled on accept
//   tx_valid     in  1  send request
//   tx_ready     out 1  high in IDLE; accept = tx_valid && tx_ready
//   tx_done      out 1  one-cycle pulse at end of transfer
//   tx_err       out 1  valid with tx_done: missing ACK or timeout
//   busy         out 1  ~tx_ready
//
// Build option: define PS2_TX_FILTER_EN to add an 8-sample glitch filter on
// the synchronised PS/2 clock.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam int MAX_IR  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CNT_MAX = (MAX_IR > TIMEOUT_CYCLES) ? MAX_IR : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_FIN
    } state_t;

    // Input synchronisers
    logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic clk_prev_q, clk_prev_d;
    logic clk_cur;
    logic fall;

    always_comb begin
        clk_s1_d  = ps2_clk_in;
        clk_s2_d  = clk_s1_q;
        data_s1_d = ps2_data_in;
        data_s2_d = data_s1_q;
        clk_prev_d = clk_cur;
    end

`ifdef PS2_TX_FILTER_EN
    // The filtered clock only follows the synchronised clock once it has
    // disagreed for 8 consecutive samples; any agreeing sample restarts the run.
    logic       clk_filt_q, clk_filt_d;
    logic [2:0] filt_cnt_q, filt_cnt_d;

    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = 3'd0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == 3'd7) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge board_clk) begin
        if (!reset) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= 3'd0;
        end else begin
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign clk_cur = clk_filt_q;
`else
    assign clk_cur = clk_s2_q;
`endif

    assign fall = clk_prev_q & ~clk_cur;

    // Transfer state
    state_t        state_q, state_d;
    logic [9:0]    frame_q, frame_d;      // {stop, parity, data}
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;          // phase timer, then device timeout
    logic          err_q, err_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          tx_ready_q, tx_ready_d;
    logic          tx_done_q, tx_done_d;
    logic          tx_err_q, tx_err_d;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = 4'd0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REQ: begin
                if (cnt_q == REQ_LAST) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = S_SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SEND, S_ACK, S_WAIT_IDLE: begin
                // A device edge always beats the timeout terminal count.
                if (fall) begin
                    cnt_d = '0;
                    if (state_q == S_SEND) begin
                        data_oe_d = ~frame_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end else if (state_q == S_ACK) begin
                        err_d   = data_s2_q;
                        state_d = S_WAIT_IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d     = '0;
                    err_d     = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = S_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (state_q == S_WAIT_IDLE && clk_cur && data_s2_q) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_FIN) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end

        tx_done_d  = (state_d == S_FIN);
        tx_err_d   = (state_d == S_FIN) & err_d;
        tx_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge board_clk) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            clk_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= 4'd0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_ready    = tx_ready_q;
    assign tx_done     = tx_done_q;
    assign tx_err      = tx_err_q;
    assign busy        = ~tx_ready_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int REQ  = 4;
    localparam int TO   = 1000;
    localparam int HALF = 40;

    logic       board_clk = 1'b0;
    logic       reset     = 1'b0;
    logic       dev_clk   = 1'b1;
    logic       dev_data  = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err, busy;
    logic       clk_line, data_line;

    // Open-drain bus: low if either side pulls it low.
    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .busy       (busy)
    );

    always #5 board_clk = ~board_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic [9:0] exp_frame;
        logic       exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic start_tx(input logic [7:0] d);
        @(negedge board_clk);
        check("ready_before_accept", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge board_clk);
        #1;
        tx_valid = 1'b0;
        check("accept_clk_oe_ready_busy", {ps2_clk_oe, tx_ready, busy}, 3'b101);
    endtask

    // Returns at #1 after the edge on which the clock is released for SEND.
    task automatic wait_send();
        int n;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge board_clk);
            #1;
            if (!ps2_clk_oe && ps2_data_oe) begin
                n = i;
                break;
            end
        end
        check("send_entry_cycles", n, INH + REQ);
        check("start_bit", data_line, 1'b0);
    endtask

    task automatic device_bits(input int nfalls, output logic [9:0] got);
        got = '1;
        repeat (HALF) @(posedge board_clk);
        #1;
        for (int b = 0; b < nfalls; b++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(posedge board_clk);
            #1;
            got[b]  = data_line;
            dev_clk = 1'b1;
            repeat (HALF) @(posedge board_clk);
            #1;
        end
    endtask

    task automatic device_ack(input logic ack);
        dev_data = ~ack;
        repeat (4) @(posedge board_clk);
        #1;
        dev_clk = 1'b0;
        repeat (HALF) @(posedge board_clk);
        #1;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge board_clk);
            #1;
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1'b1);
    endtask

    task automatic run_vec(input logic [7:0] d, input logic ack,
                           input logic [9:0] exp_frame, input logic exp_err);
        logic [9:0] got;
        start_tx(d);
        wait_send();
        device_bits(10, got);
        check("frame_bits", got, exp_frame);
        device_ack(ack);
        wait_done();
        check("tx_err", tx_err, exp_err);
        @(posedge board_clk);
        #1;
        check("post_done_oe_ready_busy_done", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done}, 5'b00100);
    endtask

    initial begin
        logic [9:0] got;
        int         n;
        logic [3:0] exp_glitch_cnt;

        // frame = {stop, odd parity, data}
        vecs[0] = '{data: 8'hED, ack: 1'b1, exp_frame: 10'h3ED, exp_err: 1'b0};
        vecs[1] = '{data: 8'h00, ack: 1'b1, exp_frame: 10'h300, exp_err: 1'b0};
        vecs[2] = '{data: 8'hA5, ack: 1'b0, exp_frame: 10'h3A5, exp_err: 1'b1};
        vecs[3] = '{data: 8'h80, ack: 1'b1, exp_frame: 10'h280, exp_err: 1'b0};
        vecs[4] = '{data: 8'h01, ack: 1'b1, exp_frame: 10'h201, exp_err: 1'b0};

        reset = 1'b0;
        repeat (3) @(posedge board_clk);
        #1;
        check("reset_state", {ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err, busy}, 6'b001000);
        reset = 1'b1;
        repeat (5) @(posedge board_clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v].data, vecs[v].ack, vecs[v].exp_frame, vecs[v].exp_err);
        end

        // Device never clocks: timeout exactly TO cycles after SEND entry.
        start_tx(8'h5A);
        wait_send();
        n = 0;
        for (int i = 1; i <= TO + 100; i++) begin
            @(posedge board_clk);
            #1;
            if (tx_done) begin
                n = i;
                break;
            end
        end
        check("timeout_cycles", n, TO);
        check("timeout_err_oe", {tx_err, ps2_clk_oe, ps2_data_oe}, 3'b100);
        @(posedge board_clk);
        #1;
        check("timeout_ready", tx_ready, 1'b1);

        // Reset after fall 4 of a 0xFF send, then a clean 0xEE send.
        start_tx(8'hFF);
        wait_send();
        device_bits(4, got);
        check("ff_first_bits", got[3:0], 4'hF);
        reset = 1'b0;
        @(posedge board_clk);
        #1;
        check("midreset_state", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_err}, 6'b001000);
        reset = 1'b1;
        repeat (5) @(posedge board_clk);
        #1;
        run_vec(8'hEE, 1'b1, 10'h3EE, 1'b0);

        // 3-cycle low glitch on the device clock during SEND.
        start_tx(8'h00);
        wait_send();
        device_bits(2, got);
        check("glitch_cnt_before", dut.bit_cnt_q, 4'd2);
        dev_clk = 1'b0;
        repeat (3) @(posedge board_clk);
        #1;
        dev_clk = 1'b1;
        repeat (20) @(posedge board_clk);
        #1;
`ifdef PS2_TX_FILTER_EN
        exp_glitch_cnt = 4'd2;
`else
        exp_glitch_cnt = 4'd3;
`endif
        check("glitch_cnt_after", dut.bit_cnt_q, exp_glitch_cnt);
        reset = 1'b0;
        @(posedge board_clk);
        #1;
        reset = 1'b1;
        check("glitch_cleanup_ready", tx_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
